mult8_seq_ctrl: RTL
===================

Name: mult8_seq_ctrl

Overview:
Sequencer that computes an unsigned 8x8 -> 16-bit product by time-multiplexing a single 4x4 combinational array multiplier over four cycles.
It splits the operands into nibbles, steps through the four nibble products, and shift-accumulates them into a 16-bit register.
It sits between a requester using a valid/ready handshake and the shared 4x4 multiplier cell, trading area for latency.

Parameters:
None. Operand width is fixed at 8 bits by the 4x4 cell and the nibble schedule.

Ports:
clk        input   1   rising-edge clock
rst_n      input   1   asynchronous active-low reset
in_valid   input   1   operand pair presented
in_ready   output  1   controller can accept operands
a          input   8   multiplicand, unsigned
b          input   8   multiplier, unsigned
flush      input   1   synchronous abort; returns the controller to IDLE
out_valid  output  1   product valid; held until accepted
out_ready  input   1   consumer accepts product
product    output  16  a*b, unsigned
busy       output  1   high in MUL state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, step=0, acc=0, operand regs=0.
  - in_ready=1, out_valid=0, busy=0, product=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b into a_r and b_r, clear acc, step=0, go to MUL.
  - MUL: busy=1, in_ready=0. Each cycle the cell is fed one nibble pair:
    - step0: a_r[3:0]*b_r[3:0], added to acc with shift 0
    - step1: a_r[7:4]*b_r[3:0], shift 4
    - step2: a_r[3:0]*b_r[7:4], shift 4
    - step3: a_r[7:4]*b_r[7:4], shift 8
  - MUL (cont.): step increments each cycle. After step3 is accumulated, go to DONE.
  - DONE: out_valid=1, product=acc (registered, stable). On out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept of new operands.
- Latency:
  - Acceptance at edge k leaves out_valid high after edge k+4.
  - Minimum initiation interval is 6 cycles with out_ready tied high.
- Arithmetic:
  - Each 8-bit nibble product is zero-extended to 16 bits before shifting.
  - acc is 16 bits and never overflows, since the maximum is 255*255 = 65025.
- Operands:
  - a and b are sampled only on the accepting edge.
  - Input changes during MUL or DONE have no effect.
- flush:
  - High on any edge: state=IDLE, out_valid=0, busy=0, acc cleared, product=0.
  - flush overrides a same-cycle in_valid handshake (operands not accepted) and a same-cycle out_ready.
- out_ready in IDLE or MUL is ignored.
- Back-pressure: DONE holds indefinitely with product stable while out_ready=0.
- Asynchronous reset mid-operation aborts immediately with the reset values above. No partial result is ever presented.
- Inputs and outputs are X-free after reset; the step counter saturates logically because the FSM leaves MUL at step3.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, MUL=2'd1, DONE=2'd2
  - NIB_W=4, OP_W=8, PROD_W=16
  - LAST_STEP=2'd3
- Sub-module: instantiate the existing 4x4 array multiplier cell once. Nibble selection is a mux driven by step; the shift amount is decoded from step (0 -> 0, 1/2 -> 4, 3 -> 8).
- Controller FSM and accumulator stay in this module.

Test Plan:
- Reset mid-MUL:
  - Stimulus: accept a=8'hFF, b=8'hFF, then assert rst_n=0 during step2.
  - Required response: outputs immediately return to reset values (in_ready=1, out_valid=0, product=0). A following a=3, b=5 yields product=16'd15.
- Basic:
  - Stimulus: a=8'd12, b=8'd10 accepted at edge k, out_ready=1.
  - Required response: out_valid high after edge k+4, product=16'd120. in_ready high again two cycles later.
- Max operands:
  - Stimulus: a=8'hFF, b=8'hFF.
  - Required response: product=16'hFE01, with no overflow in any step.
- Nibble-cross check:
  - Stimulus: a=8'hA0, b=8'h0B.
  - Required response: product=16'h06E0 (only step1 contributes). Then a=8'h0C, b=8'hD0 gives 16'h09C0 (only step2 contributes).
- Back-pressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises, with a/b and in_valid toggled randomly meanwhile.
  - Required response: product stable, in_ready=0 throughout. Release gives exactly one transfer, then IDLE.
- Flush:
  - Stimulus: flush=1 at step1; then flush=1 in DONE with out_ready=1 in the same cycle; then flush=1 in IDLE with in_valid=1.
  - Required response: IDLE next cycle in each case, out_valid=0, no transfer. In the IDLE case the operands are not accepted, so no MUL follows.

Source files
------------

// File: rtl/mult8_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult8_seq_ctrl_pkg
//  Description : Shared constants for the nibble-serial 8x8 multiplier
//                sequencer: widths, FSM state encoding, last step index and
//                the step-to-shift decode used by the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult8_seq_ctrl_pkg;

    localparam int NIB_W  = 4;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Index of the final nibble product (a_hi * b_hi)
    localparam logic [1:0] LAST_STEP = 2'd3;

    // Weight of each nibble product: lo*lo -> 0, cross terms -> 4, hi*hi -> 8
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] shamt;
        case (step)
            2'd0:    shamt = 4'd0;
            2'd1,
            2'd2:    shamt = 4'd4;
            default: shamt = 4'd8;
        endcase
        return shamt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult8_seq_ctrl_mul4x4.sv
`default_nettype none
// ============================================================================
//  Module      : mult8_seq_ctrl_mul4x4
//  Description : Purely combinational unsigned 4x4 -> 8-bit array multiplier
//                cell built from AND-gated partial-product rows.
//  Ports       : x [3:0]  in  - multiplicand nibble
//                y [3:0]  in  - multiplier nibble
//                p [7:0]  out - x*y
//  Revision    : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl_mul4x4
    import mult8_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0]   x,
    input  logic [NIB_W-1:0]   y,
    output logic [2*NIB_W-1:0] p
);

    logic [2*NIB_W-1:0] w_row [NIB_W];

    // One partial-product row per multiplier bit, pre-shifted into position
    for (genvar i = 0; i < NIB_W; i++) begin : g_row
        assign w_row[i] = {{NIB_W{1'b0}}, (x & {NIB_W{y[i]}})} << i;
    end

    // Largest result is 15*15 = 225, so the 8-bit sum cannot overflow
    assign p = w_row[0] + w_row[1] + w_row[2] + w_row[3];

endmodule
`default_nettype wire

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult8_seq_ctrl
//  Description : Unsigned 8x8 -> 16 multiplier sequencer. Latches an operand
//                pair via valid/ready, feeds one nibble pair per cycle into a
//                shared 4x4 cell over four cycles, shift-accumulates the
//                partial products and presents the result until accepted.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                in_valid/in_ready  - operand handshake (a, b)
//                a, b [7:0]         - unsigned operands
//                flush              - synchronous abort back to IDLE
//                out_valid/out_ready- result handshake
//                product [15:0]     - a*b, zero whenever out_valid is low
//                busy               - high while multiplying
//  Revision    : 1.0 - initial release
// ============================================================================
module mult8_seq_ctrl
    import mult8_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [1:0]          r_step;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [PROD_W-1:0]   r_acc;

    logic                w_accept;
    logic [NIB_W-1:0]    w_nib_a;
    logic [NIB_W-1:0]    w_nib_b;
    logic [2*NIB_W-1:0]  w_cell_p;
    logic [PROD_W-1:0]   w_term;

    // flush wins over a same-cycle input handshake
    assign w_accept = (r_state == IDLE) && in_valid && !flush;

    // step bit 0 selects the high nibble of a, bit 1 the high nibble of b,
    // giving the order lo*lo, hi*lo, lo*hi, hi*hi
    assign w_nib_a = r_step[0] ? r_a[OP_W-1:NIB_W] : r_a[NIB_W-1:0];
    assign w_nib_b = r_step[1] ? r_b[OP_W-1:NIB_W] : r_b[NIB_W-1:0];

    mult8_seq_ctrl_mul4x4 u_cell (
        .x (w_nib_a),
        .y (w_nib_b),
        .p (w_cell_p)
    );

    assign w_term = {{(PROD_W-2*NIB_W){1'b0}}, w_cell_p} << step_shift(r_step);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: if (in_valid)              w_next_state = MUL;
                MUL:  if (r_step == LAST_STEP)   w_next_state = DONE;
                DONE: if (out_ready)             w_next_state = IDLE;
                default:                         w_next_state = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == MUL);
        out_valid = (r_state == DONE);
        // Gate so the partially accumulated value never shows on the port
        product   = (r_state == DONE) ? r_acc : '0;
    end

    // ------------------------------------------------------------------
    // Operand, step and accumulator datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_step <= '0;
            r_acc  <= '0;
        end else if (flush) begin
            r_step <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_step <= '0;
            r_acc  <= '0;
        end else if (r_state == MUL) begin
            // Wraps to 0 after LAST_STEP, but the FSM has left MUL by then
            r_step <= r_step + 2'd1;
            r_acc  <= r_acc + w_term;
        end
    end

endmodule
`default_nettype wire
